// File: rtl/conv_out_pkg.sv
// Shared constants, types and the ReLU clamp helper for the conv output writer.
// The clamp is applied only when CONV_OUT_RELU_EN is defined (see conv_out_writer).
package conv_out_pkg;

  localparam int unsigned MAC_OUT_NUM   = 18;
  localparam int unsigned DATA_WIDTH    = 8;
  localparam int unsigned CH_PER_BEAT   = 6;
  localparam int unsigned FIFO_DEPTH    = 4;
  localparam int unsigned ADDR_WIDTH    = 16;

  localparam int unsigned BEATS_PER_VEC = MAC_OUT_NUM / CH_PER_BEAT;
  localparam int unsigned BEAT_IDX_W    = (BEATS_PER_VEC > 1) ? $clog2(BEATS_PER_VEC) : 1;
  localparam int unsigned VEC_W         = MAC_OUT_NUM * DATA_WIDTH;
  localparam int unsigned BEAT_W        = CH_PER_BEAT * DATA_WIDTH;
  localparam int unsigned PTR_W         = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W         = PTR_W + 1;

  typedef logic [VEC_W-1:0]      vec_t;
  typedef logic [BEAT_W-1:0]     beat_t;
  typedef logic [BEAT_IDX_W-1:0] beat_idx_t;
  typedef logic [ADDR_WIDTH-1:0] addr_t;

  localparam beat_idx_t LAST_BEAT = beat_idx_t'(BEATS_PER_VEC - 1);

  // Negative channels become zero, non-negative channels pass unchanged.
  function automatic vec_t relu_vec(input vec_t v);
    vec_t r;
    r = v;
    for (int unsigned c = 0; c < MAC_OUT_NUM; c++) begin
      if (v[c*DATA_WIDTH + DATA_WIDTH - 1]) r[c*DATA_WIDTH +: DATA_WIDTH] = '0;
    end
    return r;
  endfunction

endpackage

// File: rtl/conv_out_fifo.sv
// Synchronous result-vector FIFO; a push into a full FIFO succeeds when a pop
// happens in the same cycle. flush_i empties it like a reset.
module conv_out_fifo
  import conv_out_pkg::*;
(
  input  logic clk,
  input  logic rst_i,
  input  logic flush_i,
  input  logic push_i,
  input  logic pop_i,
  input  vec_t din_i,
  output vec_t dout_o,
  output logic full_o,
  output logic empty_o
);

  vec_t             mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  always_comb begin
    empty_o = (count_q == '0);
    full_o  = (count_q == CNT_W'(FIFO_DEPTH));
    do_pop  = pop_i && !empty_o;
    do_push = push_i && (!full_o || do_pop);
    dout_o  = mem_q[rd_ptr_q];
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= din_i;
  end

  always_ff @(posedge clk) begin
    if (rst_i || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/conv_out_writer.sv
// Captures conv result vectors, buffers them and writes them out as beats with
// per-frame sequential addresses. Define CONV_OUT_RELU_EN to clamp negatives at push.
module conv_out_writer
  import conv_out_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  frame_start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] frame_beats,
  input  logic [VEC_W-1:0]      vec_in,
  input  logic                  vec_valid_in,
  output logic [BEAT_W-1:0]     wr_data,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic                  wr_valid,
  input  logic                  wr_ready,
  output logic                  wr_last,
  output logic                  frame_done,
  output logic                  overflow
);

  vec_t      push_data, head;
  logic      fifo_full, fifo_empty;
  logic      accept, pop, push_req, push;
  addr_t     last_cnt;
  beat_idx_t beat_q, beat_d;
  addr_t     addr_q, addr_d, base_q, base_d, fbeats_q, fbeats_d, cnt_q, cnt_d;
  logic      done_q, done_d, ovf_q, ovf_d;

`ifdef CONV_OUT_RELU_EN
  assign push_data = relu_vec(vec_in);
`else
  assign push_data = vec_in;
`endif

  conv_out_fifo u_fifo (
    .clk     (clk),
    .rst_i   (rst),
    .flush_i (frame_start),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (push_data),
    .dout_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    wr_valid = !fifo_empty;
    accept   = wr_valid && wr_ready;
    pop      = accept && (beat_q == LAST_BEAT);
    push_req = vec_valid_in && !frame_start;
    push     = push_req && (!fifo_full || pop);
    last_cnt = fbeats_q - ADDR_WIDTH'(1);
    wr_last  = wr_valid && (cnt_q == last_cnt);
    wr_addr  = addr_q;

    wr_data = '0;
    for (int unsigned b = 0; b < BEATS_PER_VEC; b++) begin
      if (wr_valid && beat_q == beat_idx_t'(b)) wr_data = head[b*BEAT_W +: BEAT_W];
    end

    beat_d   = beat_q;
    addr_d   = addr_q;
    base_d   = base_q;
    fbeats_d = fbeats_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    ovf_d    = ovf_q;

    if (frame_start) begin
      beat_d   = '0;
      cnt_d    = '0;
      addr_d   = base_addr;
      base_d   = base_addr;
      fbeats_d = frame_beats;
      ovf_d    = 1'b0;
    end else begin
      if (push_req && !push) ovf_d = 1'b1;
      if (accept) begin
        beat_d = (beat_q == LAST_BEAT) ? '0 : beat_q + 1'b1;
        // Frame boundary is independent of vector boundary: restart at base mid-vector.
        if (wr_last) begin
          cnt_d  = '0;
          addr_d = base_q;
          done_d = 1'b1;
        end else begin
          cnt_d  = cnt_q + 1'b1;
          addr_d = addr_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_q   <= '0;
      addr_q   <= '0;
      base_q   <= '0;
      fbeats_q <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      beat_q   <= beat_d;
      addr_q   <= addr_d;
      base_q   <= base_d;
      fbeats_q <= fbeats_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
    end
  end

  assign frame_done = done_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_conv_out_writer.sv
// Scoreboard bench for conv_out_writer: the driver queues expected beats as vectors
// are issued; a negedge monitor pops and compares each accepted beat.
module tb_conv_out_writer;
  import conv_out_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_start = 1'b0;
  addr_t       base_addr = '0;
  addr_t       frame_beats = '0;
  vec_t        vec_in = '0;
  logic        vec_valid_in = 1'b0;
  beat_t       wr_data;
  addr_t       wr_addr;
  logic        wr_valid;
  logic        wr_ready = 1'b0;
  logic        wr_last;
  logic        frame_done;
  logic        overflow;

  always #5 clk = ~clk;

  conv_out_writer dut (
    .clk          (clk),
    .rst          (rst),
    .frame_start  (frame_start),
    .base_addr    (base_addr),
    .frame_beats  (frame_beats),
    .vec_in       (vec_in),
    .vec_valid_in (vec_valid_in),
    .wr_data      (wr_data),
    .wr_addr      (wr_addr),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_last      (wr_last),
    .frame_done   (frame_done),
    .overflow     (overflow)
  );

  typedef struct {
    beat_t data;
    addr_t addr;
    logic  last;
  } exp_t;

  exp_t  exp_q[$];
  int    errors = 0;
  int    checks = 0;
  addr_t m_base, m_addr, m_cnt, m_fb;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endfunction

  function automatic vec_t mkvec(input logic [7:0] seed);
    vec_t v;
    for (int i = 0; i < MAC_OUT_NUM; i++) v[i*8 +: 8] = seed + 8'(i);
    return v;
  endfunction

  function automatic vec_t tb_relu(input vec_t v);
    vec_t r;
    r = v;
    for (int i = 0; i < MAC_OUT_NUM; i++)
      if (v[i*8 + 7]) r[i*8 +: 8] = 8'h00;
    return r;
  endfunction

  task automatic add_beat(input beat_t d);
    exp_t e;
    e.data = d;
    e.addr = m_addr;
    e.last = (m_cnt == m_fb - 16'd1);
    exp_q.push_back(e);
    if (e.last) begin
      m_cnt  = '0;
      m_addr = m_base;
    end else begin
      m_cnt  = m_cnt + 16'd1;
      m_addr = m_addr + 16'd1;
    end
  endtask

  task automatic add_vec(input vec_t v);
    vec_t x;
    x = v;
`ifdef CONV_OUT_RELU_EN
    x = tb_relu(v);
`endif
    for (int k = 0; k < BEATS_PER_VEC; k++) add_beat(x[k*48 +: 48]);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_vec(input vec_t v, input bit store);
    vec_in       = v;
    vec_valid_in = 1'b1;
    if (store) add_vec(v);
    step();
    vec_valid_in = 1'b0;
  endtask

  task automatic do_frame_start(input addr_t base, input addr_t beats);
    base_addr   = base;
    frame_beats = beats;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    m_base = base;
    m_addr = base;
    m_cnt  = '0;
    m_fb   = beats;
    chk("fs_addr",  64'(wr_addr),  64'(base));
    chk("fs_valid", 64'(wr_valid), 64'd0);
    chk("fs_ovf",   64'(overflow), 64'd0);
  endtask

  task automatic drain(input string name);
    for (int n = 0; n < 200; n++) begin
      if (exp_q.size() == 0 && !wr_valid) break;
      step();
    end
    chk(name, 64'(exp_q.size()), 64'd0);
    step();
    step();
  endtask

  // Monitor: compares accepted beats, hold stability while stalled, and frame_done.
  logic  hold_v = 1'b0;
  beat_t hold_d;
  addr_t hold_a;
  logic  acc_prev = 1'b0;
  logic  exp_done = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (acc_prev) chk("frame_done", 64'(frame_done), 64'(exp_done));
    acc_prev = 1'b0;
    if (rst) begin
      hold_v = 1'b0;
    end else if (wr_valid) begin
      if (hold_v) begin
        chk("hold_data", 64'(wr_data), 64'(hold_d));
        chk("hold_addr", 64'(wr_addr), 64'(hold_a));
      end
      if (wr_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got data %0h addr %0h, expected none", wr_data, wr_addr);
        end else begin
          e = exp_q.pop_front();
          chk("beat_data", 64'(wr_data), 64'(e.data));
          chk("beat_addr", 64'(wr_addr), 64'(e.addr));
          chk("beat_last", 64'(wr_last), 64'(e.last));
          exp_done = e.last;
          acc_prev = 1'b1;
        end
        hold_v = 1'b0;
      end else begin
        hold_v = 1'b1;
        hold_d = wr_data;
        hold_a = wr_addr;
      end
    end else begin
      hold_v = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    vec_t v;
    m_base = '0; m_addr = '0; m_cnt = '0; m_fb = '0;

    // Reset state
    step();
    step();
    chk("rst_valid", 64'(wr_valid),   64'd0);
    chk("rst_last",  64'(wr_last),    64'd0);
    chk("rst_done",  64'(frame_done), 64'd0);
    chk("rst_ovf",   64'(overflow),   64'd0);
    chk("rst_addr",  64'(wr_addr),    64'd0);
    chk("rst_data",  64'(wr_data),    64'd0);
    rst = 1'b0;
    step();

    // 1: two vectors, 6-beat frame at 0x0100
    do_frame_start(16'h0100, 16'd6);
    wr_ready = 1'b1;
    push_vec(mkvec(8'h10), 1'b1);
    chk("t1_latency", 64'(wr_valid), 64'd1);
    push_vec(mkvec(8'h30), 1'b1);
    drain("t1_drain");

    // 2: channel i = i, ready toggling; hand-computed beat contents
    do_frame_start(16'h0180, 16'd3);
    wr_ready = 1'b0;
    vec_in       = mkvec(8'h00);
    vec_valid_in = 1'b1;
    add_beat(48'h050403020100);
    add_beat(48'h0b0a09080706);
    add_beat(48'h11100f0e0d0c);
    step();
    vec_valid_in = 1'b0;
    for (int i = 0; i < 10; i++) begin
      wr_ready = ~wr_ready;
      step();
    end
    wr_ready = 1'b1;
    drain("t2_drain");

    // 3: stall and overflow; fifth vector dropped
    do_frame_start(16'h0200, 16'd12);
    wr_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_vec(mkvec(8'(8'h20 + 8'(i * 16))), 1'b1);
    chk("t3_ovf_before", 64'(overflow), 64'd0);
    push_vec(mkvec(8'h70), 1'b0);
    chk("t3_ovf_set", 64'(overflow), 64'd1);
    wr_ready = 1'b1;
    drain("t3_drain");
    chk("t3_ovf_sticky", 64'(overflow), 64'd1);

    // 4: full FIFO, push coincides with pop of head vector
    do_frame_start(16'h0300, 16'd40);
    wr_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_vec(mkvec(8'(8'h01 + 8'(i * 16))), 1'b1);
    wr_ready = 1'b1;
    step();
    step();
    push_vec(mkvec(8'h50), 1'b1);
    chk("t4_ovf_clear", 64'(overflow), 64'd0);
    drain("t4_drain");

    // 5: frame ends mid-vector; negative channel for ReLU builds
    do_frame_start(16'h0400, 16'd4);
    wr_ready = 1'b1;
    v = mkvec(8'h20);
    v[7:0]  = 8'hF0;
    v[15:8] = 8'h7F;
    push_vec(v, 1'b1);
    push_vec(mkvec(8'h60), 1'b1);
    drain("t5_drain");

    // 6: reset mid-vector after beat 1 accepted
    do_frame_start(16'h0500, 16'd10);
    wr_ready = 1'b1;
    v = mkvec(8'h40);
    vec_in       = v;
    vec_valid_in = 1'b1;
    add_beat(v[47:0]);
    add_beat(v[95:48]);
    step();
    vec_valid_in = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    chk("t6_valid", 64'(wr_valid), 64'd0);
    chk("t6_ovf",   64'(overflow), 64'd0);
    chk("t6_addr",  64'(wr_addr),  64'd0);
    chk("t6_data",  64'(wr_data),  64'd0);
    rst = 1'b0;
    step();
    step();
    step();
    chk("t6_empty", 64'(wr_valid), 64'd0);
    chk("t6_queue", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
